// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access size codes and
// the size/alignment legality rule used at request accept.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_BAD = 2'd3;

  // True when the size code is illegal or the low address bits break natural alignment.
  function automatic logic size_addr_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    size_addr_bad = 1'b0;
      SZ_H:    size_addr_bad = lo[0];
      SZ_W:    size_addr_bad = (lo != 2'b00);
      default: size_addr_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and the core: load extraction with
// sign/zero extension, and store merge of a byte/half into a read word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rdata,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   size,
  input  logic [1:0]   lane,
  input  logic         uns,
  output logic [W-1:0] ld_data,
  output logic [W-1:0] st_data
);

  logic signed [7:0]  b_v;
  logic signed [15:0] h_v;

  always_comb begin
    b_v     = rdata[{lane, 3'b000} +: 8];
    h_v     = rdata[{lane[1], 4'b0000} +: 16];
    ld_data = rdata;
    st_data = rdata;
    case (size)
      SZ_B: begin
        ld_data = uns ? {{(W-8){1'b0}}, b_v} : {{(W-8){b_v[7]}}, b_v};
        st_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ld_data = uns ? {{(W-16){1'b0}}, h_v} : {{(W-16){h_v[15]}}, h_v};
        st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_W: st_data = wdata;
      default: begin
        ld_data = rdata;
        st_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store, read-modify-write for
// sub-word stores, registered memory strobes and a held response channel.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 5,
  parameter int AW  = $clog2(N),
  parameter int BAW = $clog2(N) + 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_unsigned,
  input  logic [BAW-1:0] req_addr,
  input  logic [W-1:0]   req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_rdata,
  output logic           rsp_err,
  output logic [AW-1:0]  mem_address,
  output logic           mem_read,
  output logic           mem_write,
  output logic [W-1:0]   mem_wdata,
  input  logic [W-1:0]   mem_rdata
);

  state_t       state;
  logic         cap_we;
  logic [1:0]   cap_size;
  logic         cap_uns;
  logic [1:0]   cap_lane;
  logic [W-1:0] cap_wdata;
  logic [W-1:0] ld_data;
  logic [W-1:0] st_data;
  logic         req_bad;

  assign req_ready = (state == IDLE);
  assign req_bad   = size_addr_bad(req_size, req_addr[1:0]) ||
                     ({1'b0, req_addr[BAW-1:2]} >= (AW+1)'(N));

  lsu_lane_align #(.W(W)) u_align (
    .rdata   (mem_rdata),
    .wdata   (cap_wdata),
    .size    (cap_size),
    .lane    (cap_lane),
    .uns     (cap_uns),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Request capture: pure datapath, only consumed once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      cap_we    <= req_we;
      cap_size  <= req_size;
      cap_uns   <= req_unsigned;
      cap_lane  <= req_addr[1:0];
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr[BAW-1:2];
            rsp_rdata   <= '0;
            rsp_err     <= req_bad;
            if (req_bad) begin
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (req_we && req_size == SZ_W) begin
              mem_wdata <= req_wdata;
              mem_write <= 1'b1;
              state     <= WR;
            end else begin
              mem_read <= 1'b1;
              state    <= RD;
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          state    <= RDW;
        end
        // Read word is on mem_rdata now: either finish the load or launch the merged write.
        RDW: begin
          if (cap_we) begin
            mem_wdata <= st_data;
            mem_write <= 1'b1;
            state     <= WR;
          end else begin
            rsp_rdata <= ld_data;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        WR: begin
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/backpressure
// sequences and random traffic against an arithmetic memory model.
module tb_load_store_unit;

  localparam int W   = 32;
  localparam int N   = 5;
  localparam int AW  = 3;
  localparam int BAW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_we = 1'b0;
  logic [1:0]     req_size = 2'd0;
  logic           req_unsigned = 1'b0;
  logic [BAW-1:0] req_addr = '0;
  logic [W-1:0]   req_wdata = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_rdata;
  logic           rsp_err;
  logic [AW-1:0]  mem_address;
  logic           mem_read;
  logic           mem_write;
  logic [W-1:0]   mem_wdata;
  logic [W-1:0]   mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.W(W), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // data_memory stand-in: synchronous read, write on MemWrite, strobe counters.
  logic [W-1:0] mem [N];
  int rd_total = 0;
  int wr_total = 0;
  int both_total = 0;

  always @(posedge clk) begin
    if (mem_read) begin
      if (int'(mem_address) < N) mem_rdata <= mem[mem_address];
      rd_total <= rd_total + 1;
    end
    if (mem_write) begin
      if (int'(mem_address) < N) mem[mem_address] <= mem_wdata;
      wr_total <= wr_total + 1;
    end
    if (mem_read && mem_write) both_total <= both_total + 1;
  end

  logic [W-1:0] ref_mem [N];
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour from the access rules; updates ref_mem for stores.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [4:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int nrd, output int nwr);
    int idx, sh;
    logic [31:0] mask, word, val;
    idx = int'(addr) / 4;
    er  = (size == 2'd3) || (size == 2'd1 && int'(addr) % 2 != 0) ||
          (size == 2'd2 && int'(addr) % 4 != 0) || idx >= N;
    rd = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (!er) begin
      word = ref_mem[idx];
      sh   = (int'(addr) % 4) * 8;
      if (size == 2'd0) mask = 32'h0000_00FF;
      else if (size == 2'd1) mask = 32'h0000_FFFF;
      else begin mask = 32'hFFFF_FFFF; sh = 0; end
      if (we) begin
        ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        nwr = 1;
        nrd = (size == 2'd2) ? 0 : 1;
        lat = (size == 2'd2) ? 2 : 4;
      end else begin
        val = (word >> sh) & mask;
        if (!uns && size != 2'd2 && (val & ((mask >> 1) + 32'd1)) != 0) val = val | ~mask;
        rd  = val;
        nrd = 1;
        lat = 3;
      end
    end
  endtask

  // Issue one request from idle with rsp_ready=1; returns response and observed behaviour.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [4:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nrd, output int nwr);
    int r0, w0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    r0 = rd_total; w0 = wr_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rsp_rdata;
    er  = rsp_err;
    nrd = rd_total - r0;
    nwr = wr_total - w0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] m_rd, d_rd, held;
    logic        m_er, d_er;
    int          m_lat, m_nrd, m_nwr, d_lat, d_nrd, d_nwr, r0, w0, wait_c;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 5'h08, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 5'h09, 32'h0,        32'hFFFF_FFBE, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 5'h09, 32'h0,        32'h0000_00BE, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 5'h0A, 32'h0,        32'hFFFF_DEAD, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 1'b0, 5'h0A, 32'h0000CAFE, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 5'h08, 32'h0,        32'hCAFE_BEEF, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 5'h0B, 32'h1234565A, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 2'd2, 1'b1, 5'h08, 32'h0,        32'h5AFE_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 5'h0A, 32'h0,        32'h0000_5AFE, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 5'h08, 32'h0,        32'h0000_00EF, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 5'h08, 32'h0,        32'hFFFF_FFEF, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 5'h06, 32'h0,        32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 5'h03, 32'h0,        32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 5'h00, 32'h0,        32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 5'h14, 32'h0,        32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 2'd2, 1'b0, 5'h14, 32'h11111111, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 2'd1, 1'b0, 5'h0B, 32'h22222222, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 5'h10, 32'h0,        32'h0000_0000, 1'b0};

    for (int i = 0; i < N; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    // The last table entry reads word 4, so give it a known value.
    mem[4] <= 32'h8765_4321;
    ref_mem[4] = 32'h8765_4321;
    vecs[17].exp_rdata = 32'h8765_4321;

    repeat (2) @(posedge clk); #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("reset_mem_write", {31'b0, mem_write}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
            m_rd, m_er, m_lat, m_nrd, m_nwr);
      run_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             d_rd, d_er, d_lat, d_nrd, d_nwr);
      check($sformatf("vec%0d_rdata", i), d_rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, d_er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), d_lat, m_lat);
      check($sformatf("vec%0d_reads", i), d_nrd, m_nrd);
      check($sformatf("vec%0d_writes", i), d_nwr, m_nwr);
    end

    // Backpressure: response held for 3 cycles while a competing request waits.
    rsp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 5'h08; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_c = 0;
    while (!rsp_valid && wait_c < 20) begin
      @(posedge clk); #1;
      wait_c++;
    end
    check("bp_latency", wait_c + 1, 3);
    held = rsp_rdata;
    check("bp_rdata", held, 32'h5AFE_BEEF);
    req_addr = 5'h0C; req_valid = 1'b1;
    r0 = rd_total;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid_held", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata_stable", rsp_rdata, held);
      check("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
    end
    check("bp_no_new_read", rd_total - r0, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rsp_done", {31'b0, rsp_valid}, 32'd0);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);

    // Reset while a byte store is in its read phase: the write must never happen.
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 5'h11;
    req_wdata = 32'h0000_0077; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_in_read", {31'b0, mem_read}, 32'd1);
    w0 = wr_total;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mid_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mid_mem_address", {29'b0, mem_address}, 32'd0);
    check("rst_mid_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_write", wr_total - w0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [4:0]  ad;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) ad[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {ad[1], 1'b0} : ad[1:0];
      wd = $urandom;
      model(we, sz, uns, ad, wd, m_rd, m_er, m_lat, m_nrd, m_nwr);
      run_op(we, sz, uns, ad, wd, d_rd, d_er, d_lat, d_nrd, d_nwr);
      check($sformatf("rnd%0d_rdata", i), d_rd, m_rd);
      check($sformatf("rnd%0d_err", i), {31'b0, d_er}, {31'b0, m_er});
      check($sformatf("rnd%0d_latency", i), d_lat, m_lat);
      check($sformatf("rnd%0d_strobes", i), (d_nrd << 4) | d_nwr, (m_nrd << 4) | m_nwr);
    end

    check("read_write_overlap", both_total, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
